// File: rtl/ml_accel_axi_pkg.sv
// Shared AXI definitions for the accelerator's DMA-facing memory model:
// response codes, FSM state encodings and the beat range check.
package ml_accel_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef logic [1:0] w_state_t;
    localparam w_state_t W_IDLE = 2'd0;
    localparam w_state_t W_DATA = 2'd1;
    localparam w_state_t W_RESP = 2'd2;

    typedef logic r_state_t;
    localparam r_state_t R_IDLE = 1'b0;
    localparam r_state_t R_DATA = 1'b1;

    // True when addr falls on a beat inside the memory window; addresses
    // below the base would wrap on subtraction, so they are rejected first.
    function automatic logic beat_in_range(
        input logic [63:0] addr,
        input logic [63:0] base_addr  = 64'h0,
        input int unsigned mem_depth  = 4096,
        input int unsigned byte_shift = 4
    );
        logic [63:0] idx;
        idx = (addr - base_addr) >> byte_shift;
        return (addr >= base_addr) && (idx < 64'(mem_depth));
    endfunction

endpackage

// File: rtl/axi_mem_bank.sv
// Beat-wide storage array: byte-enabled synchronous write port and an
// asynchronous-index read port, so a same-beat read and write returns old data.
module axi_mem_bank #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned MEM_DEPTH  = 4096
) (
    input  logic                         clk,
    input  logic                         wr_en_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] wr_idx_i,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    input  logic [DATA_WIDTH/8-1:0]      wr_strb_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] rd_idx_i,
    output logic [DATA_WIDTH-1:0]        rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // NOTE: the array has no reset; clearing it would forbid RAM inference
    // and contents must survive a reset anyway.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int unsigned b = 0; b < DATA_WIDTH/8; b++) begin
                if (wr_strb_i[b]) begin
                    mem_q[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
                end
            end
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 INCR-burst memory slave standing in for external RAM on the DMA link;
// independent write and read FSMs share one dual-port beat array.
module axi_mem_responder
    import ml_accel_axi_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 128,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           MEM_DEPTH  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,

    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int unsigned           BYTES     = DATA_WIDTH / 8;
    localparam int unsigned           SHIFT     = $clog2(BYTES);
    localparam int unsigned           IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BYTES);

    function automatic logic [IDX_W-1:0] beat_index(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> SHIFT);
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return beat_in_range(64'(addr), 64'(BASE_ADDR), MEM_DEPTH, SHIFT);
    endfunction

    // Write channel state
    w_state_t              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [7:0]            w_cnt_q,   w_cnt_d;
    logic                  w_err_q,   w_err_d;
    logic                  awready_q, awready_d;
    logic                  mem_wr_en;

    // Read channel state; ar_addr_q always points at the beat to load next
    r_state_t              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [7:0]            r_cnt_q,   r_cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [1:0]            rresp_q,   rresp_d;
    logic                  rlast_q,   rlast_d;
    logic                  arready_q, arready_d;

    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    assign rd_addr = (r_state_q == R_IDLE) ? s_axi_araddr : ar_addr_q;
    assign rd_ok   = in_range(rd_addr);

    axi_mem_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_bank (
        .clk       (clk),
        .wr_en_i   (mem_wr_en & rst_n),
        .wr_idx_i  (beat_index(aw_addr_q)),
        .wr_data_i (s_axi_wdata),
        .wr_strb_i (s_axi_wstrb),
        .rd_idx_i  (beat_index(rd_addr)),
        .rd_data_o (mem_rd_data)
    );

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        w_state_d = w_state_q;
        aw_addr_d = aw_addr_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        mem_wr_en = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid && awready_q) begin
                    aw_addr_d = s_axi_awaddr;
                    w_cnt_d   = s_axi_awlen;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid) begin
                    mem_wr_en = in_range(aw_addr_q);
                    if (!in_range(aw_addr_q)) w_err_d = 1'b1;
                    aw_addr_d = aw_addr_q + ADDR_STEP;
                    if (w_cnt_q == 8'd0) w_state_d = W_RESP;
                    else                 w_cnt_d   = w_cnt_q - 8'd1;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_err_d   = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
    end

    always_comb begin
        r_state_d = r_state_q;
        ar_addr_d = ar_addr_q;
        r_cnt_d   = r_cnt_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid && arready_q) begin
                    ar_addr_d = s_axi_araddr + ADDR_STEP;
                    r_cnt_d   = s_axi_arlen;
                    rlast_d   = (s_axi_arlen == 8'd0);
                    rdata_d   = rd_ok ? mem_rd_data : '0;
                    rresp_d   = rd_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        // Next beat loads on the accepting edge so rvalid never drops
                        ar_addr_d = ar_addr_q + ADDR_STEP;
                        r_cnt_d   = r_cnt_q - 8'd1;
                        rlast_d   = (r_cnt_q == 8'd1);
                        rdata_d   = rd_ok ? mem_rd_data : '0;
                        rresp_d   = rd_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            aw_addr_q <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
            r_state_q <= R_IDLE;
            ar_addr_q <= '0;
            r_cnt_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= AXI_RESP_OKAY;
            rlast_q   <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            aw_addr_q <= aw_addr_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
            r_state_q <= r_state_d;
            ar_addr_q <= ar_addr_d;
            r_cnt_q   <= r_cnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            arready_q <= arready_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = (w_state_q == W_DATA);
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bresp   = (s_axi_bvalid && w_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: single beats, bursts, strobes, range
// errors, backpressure and reset in the middle of concurrent bursts.
module tb_axi_mem_responder;
    import ml_accel_axi_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  s_axi_awaddr = '0;
    logic [7:0]   s_axi_awlen = '0;
    logic         s_axi_awvalid = 1'b0;
    logic         s_axi_awready;
    logic [127:0] s_axi_wdata = '0;
    logic [15:0]  s_axi_wstrb = '0;
    logic         s_axi_wvalid = 1'b0;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready = 1'b0;
    logic [31:0]  s_axi_araddr = '0;
    logic [7:0]   s_axi_arlen = '0;
    logic         s_axi_arvalid = 1'b0;
    logic         s_axi_arready;
    logic [127:0] s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rlast;
    logic         s_axi_rvalid;
    logic         s_axi_rready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] wbuf      [256];
    logic [127:0] rbuf      [256];
    logic [1:0]   rresp_buf [256];
    logic         rlast_buf [256];

    always #5 clk = ~clk;

    axi_mem_responder #(
        .DATA_WIDTH (128),
        .ADDR_WIDTH (32),
        .MEM_DEPTH  (4096),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    // Write burst from wbuf; called and returns just after a falling edge.
    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                             input logic [15:0] strb, input int b_hold,
                             output logic [1:0] resp, output int w_lat,
                             output int b_lat, output int hold_viol);
        int t;
        resp = 2'b11; w_lat = 0; b_lat = 0; hold_viol = 0;
        s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awvalid = 1'b1;
        t = 0;
        while (!s_axi_awready && t < 100) begin @(negedge clk); t++; end
        if (!s_axi_awready) begin
            n_checks++; n_fail++; s_axi_awvalid = 1'b0;
            $display("FAIL aw_timeout: awready stayed %b, required 1", s_axi_awready);
            return;
        end
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            s_axi_wdata = wbuf[b]; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
            t = 0;
            while (!s_axi_wready && t < 100) begin
                @(negedge clk); t++;
                if (b == 0) w_lat++;
            end
            if (!s_axi_wready) begin
                n_checks++; n_fail++; s_axi_wvalid = 1'b0;
                $display("FAIL w_timeout: wready stayed %b at beat %0d, required 1", s_axi_wready, b);
                return;
            end
            if (s_axi_awready) hold_viol++;
            @(negedge clk);
        end
        s_axi_wvalid = 1'b0;
        t = 0;
        while (!s_axi_bvalid && t < 100) begin @(negedge clk); t++; b_lat++; end
        if (!s_axi_bvalid) begin
            n_checks++; n_fail++;
            $display("FAIL b_timeout: bvalid stayed %b, required 1", s_axi_bvalid);
            return;
        end
        resp = s_axi_bresp;
        for (int k = 0; k < b_hold; k++) begin
            if (!s_axi_bvalid || s_axi_bresp !== resp || s_axi_awready) hold_viol++;
            @(negedge clk);
        end
        if (!s_axi_bvalid || s_axi_bresp !== resp || s_axi_awready) hold_viol++;
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
    endtask

    // Read burst into rbuf; rready held high or toggled every cycle.
    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                            input bit toggle, output int first_lat,
                            output int cycles, output int stall_viol);
        int t, beat;
        logic r_val, stalled, held_last;
        logic [127:0] held;
        first_lat = 0; cycles = 0; stall_viol = 0;
        s_axi_araddr = addr; s_axi_arlen = len; s_axi_arvalid = 1'b1;
        t = 0;
        while (!s_axi_arready && t < 100) begin @(negedge clk); t++; end
        if (!s_axi_arready) begin
            n_checks++; n_fail++; s_axi_arvalid = 1'b0;
            $display("FAIL ar_timeout: arready stayed %b, required 1", s_axi_arready);
            return;
        end
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        while (!s_axi_rvalid && first_lat < 100) begin @(negedge clk); first_lat++; end
        beat = 0; stalled = 1'b0; held = '0; held_last = 1'b0;
        r_val = toggle ? 1'b0 : 1'b1;
        while (beat <= int'(len) && cycles < 2000) begin
            s_axi_rready = r_val;
            if (s_axi_rvalid) begin
                if (stalled && (s_axi_rdata !== held || s_axi_rlast !== held_last)) stall_viol++;
                if (r_val) begin
                    rbuf[beat] = s_axi_rdata; rresp_buf[beat] = s_axi_rresp;
                    rlast_buf[beat] = s_axi_rlast; beat++; stalled = 1'b0;
                end else begin
                    stalled = 1'b1; held = s_axi_rdata; held_last = s_axi_rlast;
                end
            end
            cycles++;
            @(negedge clk);
            if (toggle) r_val = ~r_val;
        end
        s_axi_rready = 1'b0;
        if (beat <= int'(len)) begin
            n_checks++; n_fail++;
            $display("FAIL r_timeout: %0d beats received, required %0d", beat, int'(len) + 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (s_axi_awready !== 1'b0) begin n_fail++; $display("FAIL reset_awready: got %b required 0", s_axi_awready); end
        n_checks++; if (s_axi_arready !== 1'b0) begin n_fail++; $display("FAIL reset_arready: got %b required 0", s_axi_arready); end
        n_checks++; if (s_axi_wready !== 1'b0) begin n_fail++; $display("FAIL reset_wready: got %b required 0", s_axi_wready); end
        n_checks++; if (s_axi_bvalid !== 1'b0) begin n_fail++; $display("FAIL reset_bvalid: got %b required 0", s_axi_bvalid); end
        n_checks++; if (s_axi_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b required 0", s_axi_rvalid); end
        n_checks++; if (s_axi_rlast !== 1'b0) begin n_fail++; $display("FAIL reset_rlast: got %b required 0", s_axi_rlast); end
        n_checks++; if (s_axi_bresp !== 2'b00) begin n_fail++; $display("FAIL reset_bresp: got %b required 00", s_axi_bresp); end
        n_checks++; if (s_axi_rresp !== 2'b00) begin n_fail++; $display("FAIL reset_rresp: got %b required 00", s_axi_rresp); end
        n_checks++; if (s_axi_rdata !== 128'h0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", s_axi_rdata); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (s_axi_awready !== 1'b1) begin n_fail++; $display("FAIL release_awready: got %b required 1", s_axi_awready); end
        n_checks++; if (s_axi_arready !== 1'b1) begin n_fail++; $display("FAIL release_arready: got %b required 1", s_axi_arready); end
    endtask

    task automatic test_single_beat();
        logic [1:0] resp; int w_lat, b_lat, hv, fl, cyc, sv;
        wbuf[0] = 128'h0123456789ABCDEF0123456789ABCDEF;
        axi_write(32'h10, 8'd0, 16'hFFFF, 0, resp, w_lat, b_lat, hv);
        n_checks++; if (resp !== AXI_RESP_OKAY) begin n_fail++; $display("FAIL single_bresp: got %b required 00", resp); end
        n_checks++; if (w_lat !== 0) begin n_fail++; $display("FAIL single_wready_lat: got %0d extra cycles required 0", w_lat); end
        n_checks++; if (b_lat !== 0) begin n_fail++; $display("FAIL single_bvalid_lat: got %0d extra cycles required 0", b_lat); end
        n_checks++; if (hv !== 0) begin n_fail++; $display("FAIL single_awready_hold: got %0d violations required 0", hv); end
        axi_read(32'h10, 8'd0, 1'b0, fl, cyc, sv);
        n_checks++; if (fl !== 0) begin n_fail++; $display("FAIL single_rvalid_lat: got %0d extra cycles required 0", fl); end
        n_checks++; if (rbuf[0] !== 128'h0123456789ABCDEF0123456789ABCDEF) begin n_fail++; $display("FAIL single_rdata: got %h required 0123456789abcdef0123456789abcdef", rbuf[0]); end
        n_checks++; if (rlast_buf[0] !== 1'b1) begin n_fail++; $display("FAIL single_rlast: got %b required 1", rlast_buf[0]); end
        n_checks++; if (rresp_buf[0] !== AXI_RESP_OKAY) begin n_fail++; $display("FAIL single_rresp: got %b required 00", rresp_buf[0]); end
    endtask

    task automatic test_burst();
        logic [1:0] resp; int w_lat, b_lat, hv, fl, cyc, sv;
        for (int i = 0; i < 16; i++) wbuf[i] = 128'(i);
        axi_write(32'h100, 8'd15, 16'hFFFF, 0, resp, w_lat, b_lat, hv);
        n_checks++; if (resp !== AXI_RESP_OKAY) begin n_fail++; $display("FAIL burst_bresp: got %b required 00", resp); end
        n_checks++; if (hv !== 0) begin n_fail++; $display("FAIL burst_awready_hold: got %0d violations required 0", hv); end
        axi_read(32'h100, 8'd15, 1'b0, fl, cyc, sv);
        n_checks++; if (cyc !== 16) begin n_fail++; $display("FAIL burst_cycles: got %0d required 16", cyc); end
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (rbuf[i] !== 128'(i)) begin n_fail++; $display("FAIL burst_rdata[%0d]: got %h required %h", i, rbuf[i], 128'(i)); end
            n_checks++; if (rlast_buf[i] !== (i == 15)) begin n_fail++; $display("FAIL burst_rlast[%0d]: got %b required %b", i, rlast_buf[i], (i == 15)); end
        end
        n_checks++; if (s_axi_arready !== 1'b1) begin n_fail++; $display("FAIL burst_arready_return: got %b required 1", s_axi_arready); end
    endtask

    task automatic test_long_burst();
        logic [1:0] resp; int w_lat, b_lat, hv, fl, cyc, sv, bad;
        for (int i = 0; i < 256; i++) wbuf[i] = 128'(i) | 128'h7700_0000;
        axi_write(32'h1000, 8'd255, 16'hFFFF, 0, resp, w_lat, b_lat, hv);
        n_checks++; if (resp !== AXI_RESP_OKAY) begin n_fail++; $display("FAIL long_bresp: got %b required 00", resp); end
        n_checks++; if (b_lat !== 0) begin n_fail++; $display("FAIL long_bvalid_lat: got %0d required 0", b_lat); end
        axi_read(32'h1000, 8'd255, 1'b0, fl, cyc, sv);
        n_checks++; if (cyc !== 256) begin n_fail++; $display("FAIL long_cycles: got %0d required 256", cyc); end
        bad = 0;
        for (int i = 0; i < 256; i++) if (rbuf[i] !== (128'(i) | 128'h7700_0000) || rlast_buf[i] !== (i == 255)) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL long_beats: got %0d bad beats required 0", bad); end
    endtask

    task automatic test_strobes();
        logic [1:0] resp; int w_lat, b_lat, hv, fl, cyc, sv;
        wbuf[0] = {128{1'b1}};
        axi_write(32'h200, 8'd0, 16'hFFFF, 0, resp, w_lat, b_lat, hv);
        wbuf[0] = 128'h11111111_11111111_11111111_11111111;
        axi_write(32'h200, 8'd0, 16'h000F, 0, resp, w_lat, b_lat, hv);
        axi_read(32'h200, 8'd0, 1'b0, fl, cyc, sv);
        n_checks++; if (rbuf[0] !== 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_11111111) begin n_fail++; $display("FAIL strobe_rdata: got %h required ffffffffffffffffffffffff11111111", rbuf[0]); end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; int w_lat, b_lat, hv, fl, cyc, sv;
        axi_read(32'h0001_0000, 8'd0, 1'b0, fl, cyc, sv);
        n_checks++; if (rresp_buf[0] !== AXI_RESP_SLVERR) begin n_fail++; $display("FAIL oor_read_rresp: got %b required 10", rresp_buf[0]); end
        n_checks++; if (rbuf[0] !== 128'h0) begin n_fail++; $display("FAIL oor_read_rdata: got %h required 0", rbuf[0]); end
        for (int i = 0; i < 3; i++) wbuf[i] = 128'hCAFE_0000 + 128'(i);
        axi_write(32'h0, 8'd2, 16'hFFFF, 0, resp, w_lat, b_lat, hv);
        for (int i = 0; i < 4; i++) wbuf[i] = 128'hD000 + 128'(i);
        axi_write(32'hFFF0, 8'd3, 16'hFFFF, 0, resp, w_lat, b_lat, hv);
        n_checks++; if (resp !== AXI_RESP_SLVERR) begin n_fail++; $display("FAIL oor_write_bresp: got %b required 10", resp); end
        axi_read(32'hFFF0, 8'd1, 1'b0, fl, cyc, sv);
        n_checks++; if (rbuf[0] !== 128'hD000) begin n_fail++; $display("FAIL oor_last_beat: got %h required d000", rbuf[0]); end
        n_checks++; if (rresp_buf[0] !== AXI_RESP_OKAY) begin n_fail++; $display("FAIL oor_last_rresp: got %b required 00", rresp_buf[0]); end
        n_checks++; if (rresp_buf[1] !== AXI_RESP_SLVERR || rbuf[1] !== 128'h0) begin n_fail++; $display("FAIL oor_cross_beat: got resp %b data %h required 10 and 0", rresp_buf[1], rbuf[1]); end
        axi_read(32'h0, 8'd2, 1'b0, fl, cyc, sv);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (rbuf[i] !== 128'hCAFE_0000 + 128'(i)) begin n_fail++; $display("FAIL oor_no_wrap[%0d]: got %h required %h", i, rbuf[i], 128'hCAFE_0000 + 128'(i)); end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp; int w_lat, b_lat, hv, fl, cyc, sv;
        for (int i = 0; i < 8; i++) wbuf[i] = 128'h5A5A_0000 + 128'(i);
        axi_write(32'h300, 8'd7, 16'hFFFF, 0, resp, w_lat, b_lat, hv);
        axi_read(32'h300, 8'd7, 1'b1, fl, cyc, sv);
        n_checks++; if (sv !== 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d changes required 0", sv); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (rbuf[i] !== 128'h5A5A_0000 + 128'(i)) begin n_fail++; $display("FAIL bp_rdata[%0d]: got %h required %h", i, rbuf[i], 128'h5A5A_0000 + 128'(i)); end
        end
        n_checks++; if (rlast_buf[7] !== 1'b1 || rlast_buf[6] !== 1'b0) begin n_fail++; $display("FAIL bp_rlast: got %b%b required 10", rlast_buf[7], rlast_buf[6]); end
        wbuf[0] = 128'h1;
        axi_write(32'h0001_0000, 8'd0, 16'hFFFF, 5, resp, w_lat, b_lat, hv);
        n_checks++; if (resp !== AXI_RESP_SLVERR) begin n_fail++; $display("FAIL bp_bresp: got %b required 10", resp); end
        n_checks++; if (hv !== 0) begin n_fail++; $display("FAIL bp_b_hold: got %0d violations required 0", hv); end
        n_checks++; if (s_axi_awready !== 1'b1) begin n_fail++; $display("FAIL bp_awready_return: got %b required 1", s_axi_awready); end
    endtask

    task automatic test_reset_mid_burst();
        int fl, cyc, sv;
        s_axi_awaddr = 32'h400; s_axi_awlen = 8'd9; s_axi_awvalid = 1'b1;
        s_axi_araddr = 32'h300; s_axi_arlen = 8'd9; s_axi_arvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        n_checks++; if (s_axi_wready !== 1'b1 || s_axi_rvalid !== 1'b1) begin n_fail++; $display("FAIL mid_concurrent: got wready %b rvalid %b required 1 1", s_axi_wready, s_axi_rvalid); end
        s_axi_rready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            s_axi_wdata = 128'hE000 + 128'(b); s_axi_wstrb = 16'hFFFF; s_axi_wvalid = 1'b1;
            n_checks++; if (s_axi_rdata !== 128'h5A5A_0000 + 128'(b)) begin n_fail++; $display("FAIL mid_rdata[%0d]: got %h required %h", b, s_axi_rdata, 128'h5A5A_0000 + 128'(b)); end
            @(negedge clk);
        end
        s_axi_wdata = 128'hE003; rst_n = 1'b0;
        @(negedge clk);
        s_axi_wvalid = 1'b0; s_axi_rready = 1'b0;
        n_checks++; if (s_axi_awready !== 1'b0 || s_axi_arready !== 1'b0) begin n_fail++; $display("FAIL mid_in_reset_ready: got %b %b required 0 0", s_axi_awready, s_axi_arready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: got %b %b required 1 1", s_axi_awready, s_axi_arready); end
        n_checks++; if (s_axi_bvalid !== 1'b0 || s_axi_rvalid !== 1'b0 || s_axi_wready !== 1'b0) begin n_fail++; $display("FAIL mid_dropped: got bvalid %b rvalid %b wready %b required 0 0 0", s_axi_bvalid, s_axi_rvalid, s_axi_wready); end
        axi_read(32'h400, 8'd2, 1'b0, fl, cyc, sv);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (rbuf[i] !== 128'hE000 + 128'(i)) begin n_fail++; $display("FAIL mid_retained[%0d]: got %h required %h", i, rbuf[i], 128'hE000 + 128'(i)); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_burst();
        test_long_burst();
        test_strobes();
        test_out_of_range();
        test_backpressure();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
